// File: rtl/sakebi_rmii_pkg.sv
// Shared RMII definitions for the sakebi receive and transmit paths.
package sakebi_rmii_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        DATA     = 2'd2
    } rmii_state_e;

    localparam logic [1:0] RMII_DIBIT_PREAMBLE  = 2'b01;
    localparam logic [1:0] RMII_DIBIT_SFD       = 2'b11;
    localparam int         RMII_DIBITS_PER_BYTE = 4;

endpackage

// File: rtl/sakebi_rmii_dibit_packer.sv
// Packs dibits LSB-first into bytes; done_o/byte_o are combinational on the
// cycle the fourth dibit is presented so the caller can register both.
module sakebi_rmii_dibit_packer
    import sakebi_rmii_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       valid_i,
    input  logic [1:0] dibit_i,
    output logic [7:0] byte_o,
    output logic       done_o
);

    localparam logic [1:0] LAST_IDX = 2'(RMII_DIBITS_PER_BYTE - 1);

    logic [1:0] cnt_q, cnt_d;
    logic [5:0] sr_q, sr_d;

    // Only the three earlier dibits need storage; the fourth comes straight from the input.
    assign byte_o = {dibit_i, sr_q};
    assign done_o = valid_i && (cnt_q == LAST_IDX);

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else if (valid_i) begin
            cnt_d = cnt_q + 2'd1;
            sr_d  = {dibit_i, sr_q[5:2]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 2'd0;
            sr_q  <= 6'd0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/sakebi_rmii_rx_core.sv
// RMII 100 Mb/s receive front end: preamble/SFD hunt, byte assembly and a
// one-cycle beat per byte. TVALID is a pulse; there is no TREADY.
module sakebi_rmii_rx_core
    import sakebi_rmii_pkg::*;
(
    input  logic       i_rmii_REF_CLK,
    input  logic       i_RESET,
    input  logic       i_rmii_CRS_DV,
    input  logic [1:0] i_rmii_RXD,
    output logic       o_axis_TVALID,
    output logic [7:0] o_axis_TDATA
);

    rmii_state_e state_q, state_d;
    logic        low_q, low_d;
    logic        tvalid_q;
    logic [7:0]  tdata_q;
    logic        push;
    logic        pk_clear;
    logic        pk_done;
    logic [7:0]  pk_byte;

    always_comb begin
        state_d = state_q;
        low_d   = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_rmii_CRS_DV && (i_rmii_RXD == RMII_DIBIT_PREAMBLE)) begin
                    state_d = PREAMBLE;
                end
            end
            PREAMBLE: begin
                if (!i_rmii_CRS_DV) begin
                    state_d = IDLE;
                end else if (i_rmii_RXD == RMII_DIBIT_SFD) begin
                    state_d = DATA;
                end else if (i_rmii_RXD != RMII_DIBIT_PREAMBLE) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                // A lone low CRS_DV cycle is end-of-frame toggling and still carries data.
                if (!i_rmii_CRS_DV && low_q) begin
                    state_d = IDLE;
                end else begin
                    push  = 1'b1;
                    low_d = !i_rmii_CRS_DV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding the counter clear outside DATA makes every frame start at d0.
    assign pk_clear = (state_q != DATA);

    sakebi_rmii_dibit_packer u_packer (
        .clk_i   (i_rmii_REF_CLK),
        .rst_i   (i_RESET),
        .clear_i (pk_clear),
        .valid_i (push),
        .dibit_i (i_rmii_RXD),
        .byte_o  (pk_byte),
        .done_o  (pk_done)
    );

    always_ff @(posedge i_rmii_REF_CLK) begin
        if (i_RESET) begin
            state_q  <= IDLE;
            low_q    <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            low_q    <= low_d;
            tvalid_q <= pk_done;
            if (pk_done) begin
                tdata_q <= pk_byte;
            end
        end
    end

    assign o_axis_TVALID = tvalid_q;
    assign o_axis_TDATA  = tdata_q;

endmodule

// File: tb/tb_sakebi_rmii_rx_core.sv
// Directed bench for sakebi_rmii_rx_core: beats are logged by a monitor and
// compared against a per-scenario expected queue.
module tb_sakebi_rmii_rx_core;

  logic       clk;
  logic       rst;
  logic       crs_dv;
  logic [1:0] rxd;
  logic       tvalid;
  logic [7:0] tdata;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic       prev_tv = 1'b0;
  logic       b2b_seen = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] beat_q[$];
  int         beat_cyc_q[$];

  sakebi_rmii_rx_core dut (
    .i_rmii_REF_CLK (clk),
    .i_RESET        (rst),
    .i_rmii_CRS_DV  (crs_dv),
    .i_rmii_RXD     (rxd),
    .o_axis_TVALID  (tvalid),
    .o_axis_TDATA   (tdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor
  always @(negedge clk) begin
    if (tvalid) begin
      beat_q.push_back(tdata);
      beat_cyc_q.push_back(cyc);
    end
    if (tvalid && prev_tv) b2b_seen = 1'b1;
    prev_tv = tvalid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step(input logic c, input logic [1:0] d);
    crs_dv = c;
    rxd    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic preamble_sfd(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 2'b01);
    step(1'b1, 2'b11);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < 4; i++) step(1'b1, v[2*i +: 2]);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00);
  endtask

  task automatic start_scenario();
    @(negedge clk);
    beat_q.delete();
    beat_cyc_q.delete();
    exp_q.delete();
  endtask

  // scoreboard
  task automatic expect_beats(input string tag);
    int n;
    @(negedge clk);
    #1;
    check({tag, "_count"}, beat_q.size(), exp_q.size());
    n = (beat_q.size() < exp_q.size()) ? beat_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), beat_q[i], exp_q[i]);
  endtask

  initial begin
    rst    = 1'b1;
    crs_dv = 1'b0;
    rxd    = 2'b00;

    // 1. reset and false carrier
    for (int i = 0; i < 3; i++) step(1'b0, 2'b00);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tdata", tdata, 8'h00);
    rst = 1'b0;
    start_scenario();
    for (int i = 0; i < 12; i++) step(1'b1, 2'b00);
    expect_beats("false_carrier");

    // 2. single byte with latency
    idle_gap(2);
    start_scenario();
    preamble_sfd(31);
    step(1'b1, 2'b01);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    check("t2_tv_before", tvalid, 1'b0);
    step(1'b1, 2'b10);
    check("t2_tv_at_d3", tvalid, 1'b1);
    check("t2_tdata_at_d3", tdata, 8'hA5);
    idle_gap(1);
    check("t2_tv_pulse", tvalid, 1'b0);
    idle_gap(1);
    exp_q.push_back(8'hA5);
    expect_beats("single");

    // 3. burst A5, 3C
    idle_gap(3);
    start_scenario();
    preamble_sfd(31);
    send_byte(8'hA5);
    send_byte(8'h3C);
    idle_gap(5);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    expect_beats("burst");
    if (beat_cyc_q.size() == 2) check("burst_spacing", beat_cyc_q[1] - beat_cyc_q[0], 4);
    else check("burst_spacing_beats", beat_cyc_q.size(), 2);
    check("burst_tdata_hold", tdata, 8'h3C);

    // 4. CRS_DV toggling at end of frame, trailing partial byte, back to IDLE
    idle_gap(2);
    start_scenario();
    preamble_sfd(20);
    send_byte(8'hA5);
    step(1'b0, 2'b10);
    step(1'b1, 2'b10);
    step(1'b0, 2'b01);
    step(1'b1, 2'b01);
    step(1'b1, 2'b11);
    step(1'b1, 2'b11);
    idle_gap(2);
    for (int i = 0; i < 8; i++) step(1'b1, 2'b10);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    expect_beats("toggle");
    check("toggle_tdata", tdata, 8'h5A);

    // 5a. 10 aborts the hunt, so the following 11 and dibits are not data
    idle_gap(2);
    start_scenario();
    step(1'b1, 2'b01);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    step(1'b1, 2'b11);
    for (int i = 0; i < 8; i++) step(1'b1, 2'b00);
    expect_beats("bad_pre_abort");

    // 5b. abort then relock
    idle_gap(2);
    start_scenario();
    step(1'b1, 2'b01);
    step(1'b1, 2'b01);
    step(1'b1, 2'b10);
    preamble_sfd(10);
    send_byte(8'h3C);
    idle_gap(3);
    exp_q.push_back(8'h3C);
    expect_beats("bad_pre_relock");

    // 6. reset mid-frame
    idle_gap(2);
    start_scenario();
    preamble_sfd(31);
    step(1'b1, 2'b01);
    step(1'b1, 2'b01);
    rst = 1'b1;
    step(1'b1, 2'b10);
    check("midrst_tvalid", tvalid, 1'b0);
    rst = 1'b0;
    step(1'b1, 2'b10);
    for (int i = 0; i < 6; i++) step(1'b1, 2'b10);
    expect_beats("midrst_lost");
    idle_gap(2);
    start_scenario();
    preamble_sfd(31);
    send_byte(8'h96);
    idle_gap(3);
    exp_q.push_back(8'h96);
    expect_beats("midrst_next");

    check("no_back_to_back", b2b_seen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, limit 200000 ns");
    $fatal(1);
  end

endmodule
